button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 101 ++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Two-channel push-button conditioner: synchronizes and debounces each raw button
// and emits a one-cycle press pulse when a new pressed level is accepted.

module button_conditioner_chan #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic en,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             s0;
  logic             s1;
  logic             db;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             db_nxt;
  logic             press_nxt;

  // Any synchronized sample matching the accepted level restarts the count.
  always_comb begin
    cnt_nxt   = '0;
    db_nxt    = db;
    press_nxt = 1'b0;
    if (s1 != db) begin
      if (cnt == CNT_LAST) begin
        db_nxt    = s1;
        press_nxt = s1 & en;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0    <= 1'b0;
      s1    <= 1'b0;
      db    <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s0    <= btn;
      s1    <= s0;
      db    <= db_nxt;
      cnt   <= cnt_nxt;
      press <= press_nxt;
    end
  end

  assign level = db;

endmodule

module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_l,
  input  logic btn_r,
  input  logic en,
  output logic level_l,
  output logic level_r,
  output logic press_l,
  output logic press_r
);

  // Channels share nothing but clock, reset and the pulse enable.
  button_conditioner_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_l (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_l),
    .en   (en),
    .level(level_l),
    .press(press_l)
  );

  button_conditioner_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_r (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_r),
    .en   (en),
    .level(level_r),
    .press(press_r)
  );

endmodule
